// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the state encoding, the sequential PC step and the word-alignment mask.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int unsigned PC_STEP    = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC select: branch target or PC+4 (wrapping), plus misalignment flag.
// Zero latency; no flow control.
module next_pc_sel
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);

  assign next_pc    = branch ? target : pc + ADDR_W'(PC_STEP);
  assign misaligned = (next_pc[1:0] & ALIGN_MASK) != 2'b00;

endmodule

// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch sequencer: FETCH -> WAIT (until rvalid) -> EXEC (until done) -> FETCH.
// Minimum 3 cycles per instruction; i_stall holds EXEC, memory latency holds WAIT; HALT is absorbing.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] EOF_INST = 32'hFFFF_FFFF,
  parameter int                CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic              o_imem_req,
  input  logic [INST_W-1:0] i_imem_rdata,
  input  logic              i_imem_rvalid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  input  logic              i_exec_done,
  input  logic              i_branch,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_stall,
  output logic              o_halt,
  output logic              o_addr_err,
  output logic [CNT_W-1:0]  o_retired
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [INST_W-1:0]  inst_q;
  logic               addr_err_q;
  logic [CNT_W-1:0]   retired_q;

  logic [ADDR_W-1:0]  next_pc;
  logic               misaligned;
  logic               latch_inst;
  logic               retire;
  logic               set_err;

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pc         (pc_q),
    .branch     (i_branch),
    .target     (i_target),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    latch_inst = 1'b0;
    retire     = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (i_imem_rvalid) begin
          latch_inst = 1'b1;
          state_d    = (i_imem_rdata == EOF_INST) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        // A done seen under stall is dropped; execute must re-assert it.
        if (i_exec_done && !i_stall) begin
          retire = 1'b1;
          if (misaligned) begin
            set_err = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      addr_err_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      if (latch_inst)
        inst_q <= i_imem_rdata;
      if (retire && !misaligned)
        pc_q <= next_pc;
      if (set_err)
        addr_err_q <= 1'b1;
      if (retire && (retired_q != {CNT_W{1'b1}}))
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign o_imem_addr  = pc_q;
  assign o_pc         = pc_q;
  assign o_imem_req   = (state_q == S_FETCH);
  assign o_inst_valid = (state_q == S_EXEC);
  assign o_halt       = (state_q == S_HALT);
  assign o_inst       = inst_q;
  assign o_addr_err   = addr_err_q;
  assign o_retired    = retired_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; retire counter narrowed to 2 bits so saturation is reachable.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] o_imem_addr;
  logic        o_imem_req;
  logic [31:0] i_imem_rdata = '0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_inst_valid;
  logic        i_exec_done = 1'b0;
  logic        i_branch = 1'b0;
  logic [31:0] i_target = '0;
  logic        i_stall = 1'b0;
  logic        o_halt;
  logic        o_addr_err;
  logic [1:0]  o_retired;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EOF = 32'hFFFF_FFFF;

  fetch_ctrl #(
    .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0), .EOF_INST(EOF), .CNT_W(2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .o_imem_addr  (o_imem_addr),
    .o_imem_req   (o_imem_req),
    .i_imem_rdata (i_imem_rdata),
    .i_imem_rvalid(i_imem_rvalid),
    .o_pc         (o_pc),
    .o_inst       (o_inst),
    .o_inst_valid (o_inst_valid),
    .i_exec_done  (i_exec_done),
    .i_branch     (i_branch),
    .i_target     (i_target),
    .i_stall      (i_stall),
    .o_halt       (o_halt),
    .o_addr_err   (o_addr_err),
    .o_retired    (o_retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_imem_rvalid = 1'b0; i_exec_done = 1'b0;
    i_branch = 1'b0; i_stall = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
  endtask

  // Starting in FETCH: walk into WAIT, answer after lat cycles, land in EXEC/HALT.
  task automatic fetch_one(input logic [31:0] inst, input int lat);
    tick();
    for (int i = 1; i < lat; i++) tick();
    i_imem_rvalid = 1'b1; i_imem_rdata = inst;
    tick();
    i_imem_rvalid = 1'b0; i_imem_rdata = '0;
  endtask

  task automatic retire(input logic br, input logic [31:0] tgt);
    i_exec_done = 1'b1; i_branch = br; i_target = tgt;
    tick();
    i_exec_done = 1'b0; i_branch = 1'b0; i_target = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (o_pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", o_pc, 32'h0); else pass_cnt++;
    total_cnt++; if (o_imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want %h", o_imem_addr, 32'h0); else pass_cnt++;
    total_cnt++; if (o_imem_req !== 1'b1) $display("FAIL reset_req: got %b want 1", o_imem_req); else pass_cnt++;
    total_cnt++; if (o_inst_valid !== 1'b0 || o_halt !== 1'b0 || o_addr_err !== 1'b0)
      $display("FAIL reset_flags: got valid=%b halt=%b err=%b want 0 0 0", o_inst_valid, o_halt, o_addr_err); else pass_cnt++;
    total_cnt++; if (o_retired !== 2'd0 || o_inst !== 32'h0)
      $display("FAIL reset_regs: got retired=%0d inst=%h want 0 0", o_retired, o_inst); else pass_cnt++;
  endtask

  task automatic test_sequential();
    logic seen_req;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'(4 * k))
        $display("FAIL seq_addr%0d: got req=%b addr=%h want 1 %h", k, o_imem_req, o_imem_addr, 32'(4 * k)); else pass_cnt++;
      fetch_one((k < 3) ? NOP : EOF, 1);
      if (k < 3) begin
        total_cnt++; if (o_inst_valid !== 1'b1 || o_inst !== NOP)
          $display("FAIL seq_exec%0d: got valid=%b inst=%h want 1 %h", k, o_inst_valid, o_inst, NOP); else pass_cnt++;
        retire(1'b0, 32'h0);
      end
    end
    total_cnt++; if (o_halt !== 1'b1 || o_retired !== 2'd3 || o_inst_valid !== 1'b0 || o_addr_err !== 1'b0)
      $display("FAIL seq_halt: got halt=%b retired=%0d valid=%b err=%b want 1 3 0 0", o_halt, o_retired, o_inst_valid, o_addr_err); else pass_cnt++;
    seen_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_imem_rvalid = 1'b1; i_imem_rdata = NOP; i_exec_done = 1'b1;
      if (o_imem_req) seen_req = 1'b1;
      tick();
    end
    i_imem_rvalid = 1'b0; i_exec_done = 1'b0;
    total_cnt++; if (seen_req !== 1'b0 || o_halt !== 1'b1 || o_inst !== EOF || o_retired !== 2'd3)
      $display("FAIL seq_frozen: got req_seen=%b halt=%b inst=%h retired=%0d want 0 1 %h 3", seen_req, o_halt, o_inst, o_retired, EOF); else pass_cnt++;
  endtask

  task automatic test_branch();
    do_reset();
    fetch_one(NOP, 1);
    retire(1'b0, 32'h0);
    fetch_one(32'h0000_006F, 1);
    total_cnt++; if (o_pc !== 32'h4 || o_inst_valid !== 1'b1)
      $display("FAIL br_exec: got pc=%h valid=%b want 00000004 1", o_pc, o_inst_valid); else pass_cnt++;
    retire(1'b1, 32'h100);
    total_cnt++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100 || o_retired !== 2'd2)
      $display("FAIL br_target: got req=%b addr=%h retired=%0d want 1 00000100 2", o_imem_req, o_imem_addr, o_retired); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    fetch_one(NOP, 1);
    retire(1'b1, 32'h102);
    total_cnt++; if (o_halt !== 1'b1 || o_addr_err !== 1'b1)
      $display("FAIL mis_flags: got halt=%b err=%b want 1 1", o_halt, o_addr_err); else pass_cnt++;
    total_cnt++; if (o_pc !== 32'h100 || o_imem_req !== 1'b0 || o_inst_valid !== 1'b0 || o_retired !== 2'd3)
      $display("FAIL mis_pc: got pc=%h req=%b valid=%b retired=%0d want 00000100 0 0 3", o_pc, o_imem_req, o_inst_valid, o_retired); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (o_halt !== 1'b1 || o_pc !== 32'h100)
      $display("FAIL mis_sticky: got halt=%b pc=%h want 1 00000100", o_halt, o_pc); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    fetch_one(NOP, 1);
    i_stall = 1'b1; i_exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (o_pc !== 32'h0 || o_inst_valid !== 1'b1 || o_retired !== 2'd0)
        $display("FAIL stall%0d: got pc=%h valid=%b retired=%0d want 00000000 1 0", i, o_pc, o_inst_valid, o_retired); else pass_cnt++;
    end
    i_stall = 1'b0;
    retire(1'b0, 32'h0);
    total_cnt++; if (o_pc !== 32'h4 || o_imem_req !== 1'b1 || o_retired !== 2'd1)
      $display("FAIL stall_release: got pc=%h req=%b retired=%0d want 00000004 1 1", o_pc, o_imem_req, o_retired); else pass_cnt++;
  endtask

  task automatic test_latency();
    logic early_valid;
    do_reset();
    tick();
    early_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_inst_valid) early_valid = 1'b1;
      tick();
    end
    total_cnt++; if (early_valid !== 1'b0 || o_inst_valid !== 1'b0)
      $display("FAIL lat_early: got early=%b valid=%b want 0 0", early_valid, o_inst_valid); else pass_cnt++;
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'hABCD_0013;
    tick();
    i_imem_rdata = 32'h1111_1111;
    total_cnt++; if (o_inst_valid !== 1'b1 || o_inst !== 32'hABCD_0013)
      $display("FAIL lat_valid: got valid=%b inst=%h want 1 abcd0013", o_inst_valid, o_inst); else pass_cnt++;
    tick();
    i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    total_cnt++; if (o_inst !== 32'hABCD_0013 || o_inst_valid !== 1'b1)
      $display("FAIL lat_spurious: got inst=%h valid=%b want abcd0013 1", o_inst, o_inst_valid); else pass_cnt++;
    retire(1'b0, 32'h0);
    total_cnt++; if (o_pc !== 32'h4)
      $display("FAIL lat_advance: got pc=%h want 00000004", o_pc); else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    total_cnt++; if (o_pc !== 32'h0 || o_imem_req !== 1'b1 || o_inst !== 32'h0)
      $display("FAIL rst_wait: got pc=%h req=%b inst=%h want 00000000 1 00000000", o_pc, o_imem_req, o_inst); else pass_cnt++;
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'h2222_2222;
    tick();
    i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    total_cnt++; if (o_inst_valid !== 1'b0 || o_inst !== 32'h0 || o_halt !== 1'b0)
      $display("FAIL rst_stale: got valid=%b inst=%h halt=%b want 0 00000000 0", o_inst_valid, o_inst, o_halt); else pass_cnt++;
    i_imem_rvalid = 1'b1; i_imem_rdata = NOP;
    tick();
    i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    total_cnt++; if (o_inst_valid !== 1'b1 || o_inst !== NOP || o_pc !== 32'h0)
      $display("FAIL rst_refetch: got valid=%b inst=%h pc=%h want 1 %h 00000000", o_inst_valid, o_inst, o_pc, NOP); else pass_cnt++;
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    fetch_one(NOP, 1);
    retire(1'b1, 32'hFFFF_FFFC);
    fetch_one(NOP, 1);
    retire(1'b0, 32'h0);
    total_cnt++; if (o_pc !== 32'h0 || o_retired !== 2'd2)
      $display("FAIL wrap_pc: got pc=%h retired=%0d want 00000000 2", o_pc, o_retired); else pass_cnt++;
    fetch_one(NOP, 1);
    retire(1'b0, 32'h0);
    fetch_one(NOP, 1);
    retire(1'b0, 32'h0);
    total_cnt++; if (o_pc !== 32'h8 || o_retired !== 2'd3)
      $display("FAIL sat_count: got pc=%h retired=%0d want 00000008 3", o_pc, o_retired); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_misaligned();
    test_stall();
    test_latency();
    test_reset_in_wait();
    test_wrap_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Multi-cycle instruction fetch sequencer for the HW2 CPU core. It owns the architectural program counter and drives the instruction-memory read handshake. It presents each fetched instruction to the execute stage and advances the PC sequentially or by branch once execute signals completion. It also detects the end-of-program instruction and misaligned branch targets, and counts retired instructions.

## Interface
- ADDR_W, 32, PC / instruction-memory address width
- INST_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- EOF_INST, 32'hFFFF_FFFF, encoding that terminates the program
- CNT_W, 16, retired-instruction counter width
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- o_imem_addr  out  ADDR_W  instruction-memory read address
- o_imem_req  out  1  one-cycle read request
- i_imem_rdata  in  INST_W  read data, valid with i_imem_rvalid
- i_imem_rvalid  in  1  read-data strobe
- o_pc  out  ADDR_W  PC of the instruction in flight
- o_inst  out  INST_W  latched instruction
- o_inst_valid  out  1  o_inst is valid for execute
- i_exec_done  in  1  execute finished current instruction
- i_branch  in  1  redirect to i_target; sampled with i_exec_done
- i_target  in  ADDR_W  branch/jump target
- i_stall  in  1  blocks PC update while high
- o_halt  out  1  sticky; program ended or error
- o_addr_err  out  1  sticky; halted due to misaligned target
- o_retired  out  CNT_W  saturating count of retired instructions

## Operation
- States: FETCH, WAIT, EXEC, HALT.
- FETCH:
  - o_imem_req=1, o_imem_addr=o_pc.
  - Unconditionally go to WAIT next cycle.
- WAIT:
  - Hold until i_imem_rvalid=1, then latch i_imem_rdata into o_inst.
  - If i_imem_rdata==EOF_INST, go to HALT with o_halt=1. The EOF instruction is not retired.
  - Otherwise go to EXEC.
  - No timeout.
- EXEC:
  - o_inst_valid=1 for the entire state; o_inst and o_pc held stable.
  - On i_exec_done=1 and i_stall=0:
    - next_pc = i_branch ? i_target : o_pc+4.
    - Sum truncated to ADDR_W, so it wraps at 2^ADDR_W.
    - o_retired increments, saturating at all-ones.
  - If next_pc[1:0]!=0: o_pc is not updated; go to HALT with o_halt=1 and o_addr_err=1.
  - Otherwise o_pc=next_pc; go to FETCH.
  - i_exec_done with i_stall=1 is ignored: no PC update, no count. Execute must re-assert done after the stall clears.
- HALT:
  - Absorbing state; all outputs frozen; o_imem_req=0; o_inst_valid=0.
  - Only i_rst exits.
- i_imem_rvalid outside WAIT is ignored.
- i_exec_done, i_branch and i_target outside EXEC are ignored.

## Timing
- Reset values:
  - state=FETCH, o_pc=RESET_PC, o_inst=0, o_inst_valid=0.
  - o_halt=0, o_addr_err=0, o_retired=0.
  - o_imem_addr=RESET_PC.
- o_imem_req is high in the first cycle after reset deasserts.
- All outputs are registered or pure decodes of the state register. No combinational input-to-output paths.
- Earliest i_imem_rvalid is the cycle after o_imem_req.
- Minimum instruction period is 3 cycles: FETCH, WAIT with rvalid, EXEC with done.
- Updated o_pc is visible in the FETCH cycle following EXEC.
- Reset mid-operation (any state, including WAIT with a read outstanding):
  - The next cycle is the reset state.
  - A stale i_imem_rvalid arriving after reset falls in FETCH and is dropped.
- i_rst has priority over all other inputs.

## Structure
- Package fetch_ctrl_pkg holds:
  - the state enum (2-bit: FETCH, WAIT, EXEC, HALT);
  - PC_STEP=4;
  - ALIGN_MASK=2'b11.
- One combinational sub-module, next_pc_sel, computes next_pc and the misalignment flag from o_pc, i_branch and i_target.
- FSM, registers and counter live in fetch_ctrl.

## Test plan
- Reset, then sequential fetch with 1-cycle memory: instructions 0x00000013 ×3 then EOF_INST. Expect o_imem_addr 0, 4, 8, 0xC; o_halt=1; o_retired=3; o_imem_req never high after halt.
- Branch: in EXEC at pc=0x4, i_exec_done=1, i_branch=1, i_target=0x100. Expect next o_imem_addr=0x100.
- Misaligned target 0x102 on a branch. Expect o_halt=1, o_addr_err=1, o_pc stays at the branching PC.
- Stall: i_exec_done=1 with i_stall=1 for 3 cycles. Expect no PC change and o_retired unchanged; a done after the stall clears advances by exactly 4.
- Memory latency 5 cycles, plus a spurious rvalid during EXEC. Expect o_inst_valid only after the real rvalid; the spurious data is not latched.
- i_rst asserted in WAIT, followed by a late rvalid. Expect o_pc=RESET_PC, state FETCH, and o_inst=0 after reset.
